// File: rtl/fsm_serial_tx.sv
// fsm_serial_tx
//   Serial transmitter, one bit per clock. Each frame is a start bit (0),
//   DATA_BITS data bits LSB first, an optional parity bit and STOP_BITS stop
//   bits (1). The line idles high. Words arrive over a valid/ready handshake.
//   in_ready is also raised in the final stop cycle, so frames can follow
//   each other with no idle gap.
// Ports
//   clk         in   1          clock, all logic on posedge
//   reset       in   1          synchronous, active-high
//   in_data     in   DATA_BITS  word to send, sampled on handshake
//   in_valid    in   1          source has a word
//   in_ready    out  1          block can accept a word this cycle
//   tx_out      out  1          serial line, registered, idle high
//   busy        out  1          frame in progress (start..last stop bit)
//   frame_done  out  1          1-cycle pulse during the final stop-bit cycle
module fsm_serial_tx #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 tx_out,
    output logic                 busy,
    output logic                 frame_done
);

    // One counter serves both the data phase and the stop phase.
    localparam int CNT_MAX = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Parity bit for a word: even parity unless PARITY_ODD is set.
    function automatic logic parity_of(input logic [DATA_BITS-1:0] word);
        return (^word) ^ (PARITY_ODD != 32'sd0);
    endfunction

    state_t                 state_r, state_s;
    logic [CNT_W-1:0]       cnt_r, cnt_s;
    logic [DATA_BITS-1:0]   shift_r, shift_s;
    logic                   par_r, par_s;
    logic                   tx_r, tx_s;
    logic                   busy_r, busy_s;
    logic                   done_r, done_s;
    logic                   ready_r, ready_s;
    logic                   hs_s;
    logic                   last_stop_s;

    // A transfer happens only while the registered ready is high.
    assign hs_s = in_valid & ready_r;

    // Next-state logic plus the values every output register takes next.
    // Outputs are computed from the upcoming state so that each one is a
    // flop that already shows the new phase in the cycle it begins.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        shift_s     = shift_r;
        par_s       = par_r;
        tx_s        = 1'b1;
        busy_s      = 1'b0;
        done_s      = 1'b0;
        ready_s     = 1'b0;
        last_stop_s = 1'b0;

        case (state_r)
            S_IDLE: begin
                if (hs_s) begin
                    state_s = S_START;
                    cnt_s   = CNT_ZERO;
                    shift_s = in_data;
                    par_s   = parity_of(in_data);
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_START: begin
                state_s = S_DATA;
                cnt_s   = CNT_ZERO;
            end
            S_DATA: begin
                if (cnt_r == DATA_LAST) begin
                    cnt_s = CNT_ZERO;
                    if (PARITY_EN != 32'sd0) begin
                        state_s = S_PARITY;
                    end else begin
                        state_s = S_STOP;
                    end
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                    shift_s = shift_r >> 1'b1;
                end
            end
            S_PARITY: begin
                state_s = S_STOP;
                cnt_s   = CNT_ZERO;
            end
            S_STOP: begin
                if (cnt_r == STOP_LAST) begin
                    cnt_s = CNT_ZERO;
                    // A word accepted in the last stop cycle starts the next
                    // frame straight away.
                    if (hs_s) begin
                        state_s = S_START;
                        shift_s = in_data;
                        par_s   = parity_of(in_data);
                    end else begin
                        state_s = S_IDLE;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = S_IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase

        case (state_s)
            S_IDLE:   tx_s = 1'b1;
            S_START:  tx_s = 1'b0;
            S_DATA:   tx_s = shift_s[0];
            S_PARITY: tx_s = par_s;
            S_STOP:   tx_s = 1'b1;
            default:  tx_s = 1'b1;
        endcase

        last_stop_s = (state_s == S_STOP) && (cnt_s == STOP_LAST);
        busy_s      = (state_s != S_IDLE);
        done_s      = last_stop_s;
        ready_s     = (state_s == S_IDLE) || last_stop_s;
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
            cnt_r   <= CNT_ZERO;
            shift_r <= {DATA_BITS{1'b0}};
            par_r   <= 1'b0;
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            shift_r <= shift_s;
            par_r   <= par_s;
            tx_r    <= tx_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            ready_r <= ready_s;
        end
    end

    assign tx_out     = tx_r;
    assign busy       = busy_r;
    assign frame_done = done_r;
    assign in_ready   = ready_r;

endmodule
